iopage_bus_ctl: RTL and testbench
=================================

# iopage_bus_ctl

Sequencer for the CPU side of the I/O-page register bus. Accepts one CPU transfer at a time and drives the shared `iopage_*` strobes to all I/O-page devices, such as the switch/display and CPU-error register blocks. It selects read data from the device that claims the address, returns a completion acknowledge, and generates the `unibus_to` timeout pulse when no device claims the address. That pulse feeds the CPU-error register.

## Interface
- `NDEV`, 4: number of attached I/O-page devices.
- `TO_CYCLES`, 16: cycles in ADDR without any decode before a bus timeout (legal 2..255).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `req`  in  1  CPU transfer request; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; latched with `req`.
- `byte_op`  in  1  byte transfer; latched with `req`.
- `addr`  in  13  I/O-page offset; latched with `req`.
- `wdata`  in  16  write data; latched with `req`.
- `ack`  out  1  one-cycle completion pulse.
- `err`  out  1  high with `ack` when the transfer timed out.
- `rdata`  out  16  read data; valid while `ack`=1; holds until next capture.
- `unibus_to`  out  1  one-cycle timeout pulse to the CPU-error register.
- `iopage_addr`  out  13  registered address to devices.
- `iopage_data`  out  16  registered write data to devices.
- `iopage_rd`  out  1  read strobe.
- `iopage_wr`  out  1  write strobe, exactly one cycle per write.
- `iopage_byte_op`  out  1  registered byte flag.
- `dev_decode`  in  NDEV  per-device address claim; combinational from `iopage_addr`.
- `dev_data`  in  16*NDEV  per-device read data; device i occupies bits [16i+15:16i].

## Operation
- **States:** IDLE, ADDR, WR, DONE, TMO. The encoding is free.
- **IDLE:**
  - If `req`=1, latch `addr`, `wdata`, `we` and `byte_op` into the `iopage_*` registers, clear the timeout counter, and go to ADDR.
  - Otherwise stay in IDLE.
- **ADDR:**
  - `iopage_rd` = !we_latched.
  - If any `dev_decode` bit is 1:
    - Read: capture `rdata` from the lowest-index decoding device and go to DONE.
    - Write: go to WR.
  - Else, if the counter equals TO_CYCLES-1, go to TMO.
  - Else, increment the counter.
- **WR:** `iopage_wr`=1 for this single cycle; go to DONE. `dev_decode` is not re-checked.
- **DONE:** `ack`=1 and `err`=0; go to IDLE.
- **TMO:**
  - `ack`=1, `err`=1 and `unibus_to`=1.
  - `rdata` is loaded with 0 on entry.
  - Go to IDLE.
- **Multiple decodes:** the lowest index wins for read data. No error is flagged.
- **Stable bus:** `iopage_addr`, `iopage_data` and `iopage_byte_op` remain stable from ADDR entry through the cycle after `ack`. They change only on the next accepted `req`.
- **Request handling:** `req` is ignored outside IDLE and is not queued. A requester holding `req` high is served again on its first IDLE cycle.
- **Counter:** ceil(log2(TO_CYCLES)) bits; it never wraps.

## Timing
- **Reset (`reset_n` low, asynchronous):**
  - State goes to IDLE and the counter clears.
  - `ack`, `err`, `unibus_to`, `iopage_rd` and `iopage_wr` are 0.
  - `rdata`, `iopage_addr`, `iopage_data` and `iopage_byte_op` are 0.
  - Reset mid-transfer abandons the transfer: no `ack`, no write strobe, no timeout pulse.
- **Cycle numbering:** `req` is sampled at edge 0. ADDR occupies cycle 1.
- **Read with immediate decode:** `iopage_rd` is high in cycle 1; `ack` and `rdata` are valid in cycle 2.
- **Write with immediate decode:** `iopage_wr` is high in cycle 2; `ack` is high in cycle 3.
- **Late decode:** a decode first seen in ADDR cycle k (1-based) gives read `ack` at cycle k+1 and write `ack` at cycle k+2.
- **Timeout:** with no decode, ADDR lasts TO_CYCLES cycles. `ack`, `err` and `unibus_to` are high in cycle TO_CYCLES+1.
- **Decode on the last cycle:** a decode arriving in the last ADDR cycle wins over the timeout.
- **Throughput:** minimum 3 cycles per read and 4 per write, with one IDLE cycle between transfers.
- **Output type:** all outputs are registered or state-decoded only. There is no combinational path from `req` to `ack`.

## Test plan
- **Basic read:** read of 17570 with device 0 decoding and `dev_data0`=16'o123456 -> `iopage_rd` in cycle 1; `ack`=1, `err`=0, `rdata`=16'o123456 in cycle 2.
- **Basic write:** write of 16'o000060 to 17766 with device 1 decoding -> `iopage_wr` for exactly cycle 2 with `iopage_data`=16'o000060; `ack` in cycle 3.
- **Timeout:** with TO_CYCLES=16, read of 17000 with no decode -> `unibus_to`, `ack` and `err` high together in cycle 17 only; `rdata`=0; `iopage_rd` never followed by `iopage_wr`.
- **Late decode and priority:**
  - Decode asserted in ADDR cycle 16 (the last) -> normal `ack` with `err`=0, no `unibus_to`.
  - Devices 1 and 2 both decoding -> `rdata` equals device 1's data.
- **Back-to-back requests:** `req` held high for three transfers -> acks at cycles 2, 5 and 8 (reads). Every transfer uses its own latched address.
- **Reset mid-transfer:** `reset_n` low during a write's ADDR cycle -> immediate return to IDLE with all outputs 0; no `iopage_wr` and no `ack` after release until a new `req`.

Source files
------------

// File: rtl/iopage_bus_ctl_if.sv
// Bus bundle between the CPU-side sequencer and the I/O-page devices.
// Handshake: req is sampled only while the sequencer is idle; every accepted req gets exactly one ack pulse.
interface iopage_bus_ctl_if #(
    parameter int NDEV = 4
);
    logic                 req;
    logic                 we;
    logic                 byte_op;
    logic [12:0]          addr;
    logic [15:0]          wdata;
    logic                 ack;
    logic                 err;
    logic [15:0]          rdata;
    logic                 unibus_to;
    logic [12:0]          iopage_addr;
    logic [15:0]          iopage_data;
    logic                 iopage_rd;
    logic                 iopage_wr;
    logic                 iopage_byte_op;
    logic [NDEV-1:0]      dev_decode;
    logic [16*NDEV-1:0]   dev_data;

    modport master (
        output req, we, byte_op, addr, wdata, dev_decode, dev_data,
        input  ack, err, rdata, unibus_to, iopage_addr, iopage_data,
               iopage_rd, iopage_wr, iopage_byte_op
    );

    modport slave (
        input  req, we, byte_op, addr, wdata, dev_decode, dev_data,
        output ack, err, rdata, unibus_to, iopage_addr, iopage_data,
               iopage_rd, iopage_wr, iopage_byte_op
    );
endinterface

// File: rtl/iopage_bus_ctl.sv
// CPU-side I/O-page bus sequencer: one transfer at a time, lowest-index read-data select,
// and a bus timeout when no device claims the address.
module iopage_bus_ctl #(
    parameter int NDEV      = 4,
    parameter int TO_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    iopage_bus_ctl_if.slave   bus,
    output logic [2:0]        state_dbg
);
    localparam int CW = $clog2(TO_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WR   = 3'd2,
        DONE = 3'd3,
        TMO  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic            we_q;
    logic            any_decode;
    logic [15:0]     sel_data;

    assign any_decode = |bus.dev_decode;
    assign state_dbg  = state;

    // Lowest index wins when several devices claim the same address.
    always_comb begin
        sel_data = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (bus.dev_decode[i]) begin
                sel_data = bus.dev_data[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.ack       = 1'b0;
        bus.err       = 1'b0;
        bus.unibus_to = 1'b0;
        bus.iopage_rd = 1'b0;
        bus.iopage_wr = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                bus.iopage_rd = !we_q;
                if (any_decode) begin
                    state_next = we_q ? WR : DONE;
                end else if (cnt == CNT_LAST) begin
                    state_next = TMO;
                end
            end
            WR: begin
                bus.iopage_wr = 1'b1;
                state_next    = DONE;
            end
            DONE: begin
                bus.ack    = 1'b1;
                state_next = IDLE;
            end
            TMO: begin
                bus.ack       = 1'b1;
                bus.err       = 1'b1;
                bus.unibus_to = 1'b1;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus registers only load on an accepted request, so they stay stable through and after ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt                <= '0;
            we_q               <= 1'b0;
            bus.rdata          <= '0;
            bus.iopage_addr    <= '0;
            bus.iopage_data    <= '0;
            bus.iopage_byte_op <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        cnt                <= '0;
                        we_q               <= bus.we;
                        bus.iopage_addr    <= bus.addr;
                        bus.iopage_data    <= bus.wdata;
                        bus.iopage_byte_op <= bus.byte_op;
                    end
                end
                ADDR: begin
                    if (any_decode) begin
                        if (!we_q) begin
                            bus.rdata <= sel_data;
                        end
                    end else if (cnt == CNT_LAST) begin
                        bus.rdata <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iopage_bus_ctl.sv
// Directed bench for iopage_bus_ctl: read, write, timeout, late decode, priority,
// back-to-back requests and reset mid-transfer.
module tb_iopage_bus_ctl;
    logic        clk;
    logic        reset_n;
    logic [2:0]  state_dbg;
    logic        force_en;
    logic [3:0]  force_mask;
    logic [3:0]  dec;
    int          n_err;
    int          n_checks;

    iopage_bus_ctl_if #(.NDEV(4)) bus ();

    iopage_bus_ctl #(.NDEV(4), .TO_CYCLES(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Device models: each claims one fixed address unless a forced decode pattern is selected.
    always_comb begin
        dec = '0;
        if (force_en) begin
            dec = force_mask;
        end else begin
            dec[0] = (bus.iopage_addr == 13'o17570);
            dec[1] = (bus.iopage_addr == 13'o17766);
            dec[2] = (bus.iopage_addr == 13'o17772);
            dec[3] = (bus.iopage_addr == 13'o17774);
        end
    end
    assign bus.dev_decode = dec;
    assign bus.dev_data   = {16'o033333, 16'o022222, 16'o111111, 16'o123456};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic w, input logic b, input logic [12:0] a, input logic [15:0] d);
        bus.req     = 1'b1;
        bus.we      = w;
        bus.byte_op = b;
        bus.addr    = a;
        bus.wdata   = d;
    endtask

    initial begin
        logic bad;
        n_err      = 0;
        n_checks   = 0;
        reset_n    = 1'b0;
        force_en   = 1'b0;
        force_mask = '0;
        bus.req    = 1'b0;
        bus.we     = 1'b0;
        bus.byte_op = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        tick();
        tick();
        reset_n = 1'b1;

        chk("rst_state", state_dbg, 3'd0);
        chk("rst_ack", {bus.ack, bus.err, bus.unibus_to, bus.iopage_rd, bus.iopage_wr}, 5'b0);
        chk("rst_regs", {bus.rdata, bus.iopage_data}, 32'h0);
        chk("rst_addr", {bus.iopage_addr, bus.iopage_byte_op}, 14'h0);

        // Basic read
        start(1'b0, 1'b0, 13'o17570, 16'h0);
        tick();
        bus.req = 1'b0;
        chk("rd_c1_rd", bus.iopage_rd, 1'b1);
        chk("rd_c1_ack", bus.ack, 1'b0);
        tick();
        chk("rd_c2_ack_err", {bus.ack, bus.err}, 2'b10);
        chk("rd_c2_rdata", bus.rdata, 16'o123456);
        tick();
        chk("rd_c3_ack", bus.ack, 1'b0);

        // Basic byte write
        start(1'b1, 1'b1, 13'o17766, 16'o000060);
        tick();
        bus.req = 1'b0;
        chk("wr_c1_strobes", {bus.iopage_rd, bus.iopage_wr, bus.ack}, 3'b000);
        tick();
        chk("wr_c2_wr", {bus.iopage_wr, bus.ack}, 2'b10);
        chk("wr_c2_data", bus.iopage_data, 16'o000060);
        chk("wr_c2_byte", bus.iopage_byte_op, 1'b1);
        tick();
        chk("wr_c3_ack", {bus.ack, bus.err, bus.iopage_wr}, 3'b100);
        tick();
        chk("wr_c4_stable", {bus.iopage_addr, bus.iopage_data}, {13'o17766, 16'o000060});
        chk("wr_c4_quiet", {bus.ack, bus.iopage_wr}, 2'b00);

        // Timeout on an unclaimed address
        start(1'b0, 1'b0, 13'o17000, 16'h0);
        bad = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 1) bus.req = 1'b0;
            bad = bad | bus.ack | bus.err | bus.unibus_to | bus.iopage_wr | !bus.iopage_rd;
        end
        chk("tmo_addr_phase", bad, 1'b0);
        tick();
        chk("tmo_c17_flags", {bus.ack, bus.err, bus.unibus_to, bus.iopage_wr}, 4'b1110);
        chk("tmo_c17_rdata", bus.rdata, 16'h0);
        tick();
        chk("tmo_c18_quiet", {bus.ack, bus.err, bus.unibus_to}, 3'b000);

        // Decode arriving in the last ADDR cycle beats the timeout
        force_en   = 1'b1;
        force_mask = 4'b0000;
        start(1'b0, 1'b0, 13'o17000, 16'h0);
        bad = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 1) bus.req = 1'b0;
            if (c == 16) force_mask = 4'b0001;
            bad = bad | bus.ack | bus.unibus_to;
        end
        chk("late_addr_phase", bad, 1'b0);
        tick();
        force_mask = 4'b0000;
        chk("late_c17_flags", {bus.ack, bus.err, bus.unibus_to}, 3'b100);
        chk("late_c17_rdata", bus.rdata, 16'o123456);
        tick();

        // Two devices claim: lowest index supplies data
        force_mask = 4'b0110;
        start(1'b0, 1'b0, 13'o17100, 16'h0);
        tick();
        bus.req = 1'b0;
        tick();
        chk("prio_ack", {bus.ack, bus.err}, 2'b10);
        chk("prio_rdata", bus.rdata, 16'o111111);
        force_en   = 1'b0;
        force_mask = 4'b0000;
        tick();

        // req held high: three reads, each with its own latched address
        start(1'b0, 1'b0, 13'o17570, 16'h0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk($sformatf("b2b_ack_c%0d", c), bus.ack, (c == 2 || c == 5 || c == 8));
            if (c == 2) chk("b2b_rdata_0", bus.rdata, 16'o123456);
            if (c == 5) chk("b2b_rdata_1", bus.rdata, 16'o111111);
            if (c == 8) chk("b2b_rdata_2", bus.rdata, 16'o022222);
            if (c == 4) chk("b2b_addr_1", bus.iopage_addr, 13'o17766);
            if (c == 7) chk("b2b_addr_2", bus.iopage_addr, 13'o17772);
            if (c == 1) bus.addr = 13'o17766;
            if (c == 4) bus.addr = 13'o17772;
            if (c == 8) bus.req = 1'b0;
        end
        tick();

        // Reset during a write's ADDR cycle
        start(1'b1, 1'b0, 13'o17766, 16'o000777);
        tick();
        bus.req = 1'b0;
        chk("rstmid_in_addr", state_dbg, 3'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rstmid_state", state_dbg, 3'd0);
        chk("rstmid_outs", {bus.ack, bus.err, bus.unibus_to, bus.iopage_rd, bus.iopage_wr}, 5'b0);
        chk("rstmid_regs", {bus.iopage_addr, bus.iopage_byte_op}, 14'h0);
        chk("rstmid_data", {bus.rdata, bus.iopage_data}, 32'h0);
        tick();
        reset_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            bad = bad | bus.ack | bus.iopage_wr | bus.unibus_to;
        end
        chk("rstmid_after", bad, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
